uart_rx_fifo: RTL and testbench

- Parametrised successor to the fixed 8N1 UART receiver used by the memory-mapped peripheral block.
- Oversampled receiver with configurable data width, optional parity, per-word error flags and an RX FIFO.
- The CPU no longer loses bytes between polls.
- Runs entirely in the clk16 domain (16x baud tick clock); the peripheral register file pops words through a show-ahead read port.

---
 rtl/uart_rx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver (configurable width/parity) feeding a show-ahead RX FIFO.
// Everything runs in the clk16 domain; words carry per-frame parity/framing error flags.
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AW         = 3
) (
    input  logic                 clk16,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_perr,
    output logic                 rd_ferr,
    output logic                 empty,
    output logic                 full,
    output logic [AW:0]          count,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned WW = DATA_BITS + 2;
    localparam logic [CW-1:0] CntLast = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CntMid  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    BitLast = 4'(DATA_BITS - 1);
    localparam logic [AW:0]   CountFull = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CW-1:0]        cnt_q;
    logic [3:0]           bit_idx_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 perr_q, ferr_q, push_q;
    logic                 fall;

    assign fall = rx_prev_q & ~rx_s2_q;
    assign busy = (state_q != StIdle);

    always_ff @(posedge clk16 or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            push_q    <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            push_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fall) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q == CntMid) begin
                        cnt_q <= '0;
                        if (rx_s2_q) begin
                            state_q <= StIdle;
                        end else begin
                            state_q   <= StData;
                            bit_idx_q <= '0;
                            perr_q    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == CntLast) begin
                        cnt_q     <= '0;
                        // LSB arrives first, so after DATA_BITS shifts it sits at bit 0
                        data_q    <= {rx_s2_q, data_q[DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == BitLast) begin
                            state_q <= (PARITY_EN != 0) ? StParity : StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        perr_q  <= ((^data_q) ^ rx_s2_q) != PARITY_ODD[0];
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == CntLast) begin
                        // Leave at mid-stop so the next start edge keeps half a bit of margin
                        cnt_q   <= '0;
                        ferr_q  <= ~rx_s2_q;
                        push_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [WW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q;
    logic          pop, do_push, drop;
    logic [WW-1:0] head;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CountFull);
    assign pop     = rd_en & ~empty;
    assign do_push = push_q & (~full | pop);
    assign drop    = push_q & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (do_push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk16) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {data_q, perr_q, ferr_q};
        end
    end

    always_ff @(posedge clk16 or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // Storage is not reset, so the head is masked to zero while empty
    assign head    = empty ? '0 : mem_q[rd_ptr_q];
    assign rd_data = head[WW-1:2];
    assign rd_perr = head[1];
    assign rd_ferr = head[0];
    assign count   = count_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: default instance (a) and an even-parity instance (b).
module tb_uart_rx_fifo;

    logic       clk16 = 1'b0;
    logic       reset = 1'b0;

    logic       rx_a = 1'b1, rd_en_a = 1'b0, clr_a = 1'b0;
    logic [7:0] rd_data_a;
    logic       rd_perr_a, rd_ferr_a, empty_a, full_a, overrun_a, busy_a;
    logic [3:0] count_a;

    logic       rx_b = 1'b1, rd_en_b = 1'b0, clr_b = 1'b0;
    logic [7:0] rd_data_b;
    logic       rd_perr_b, rd_ferr_b, empty_b, full_b, overrun_b, busy_b;
    logic [3:0] count_b;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    bit         mon_a = 1'b0;
    bit         mon_b = 1'b0;
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];

    always #5 clk16 = ~clk16;

    uart_rx_fifo u_dut_a (
        .clk16(clk16), .reset(reset), .rx(rx_a), .rd_en(rd_en_a),
        .rd_data(rd_data_a), .rd_perr(rd_perr_a), .rd_ferr(rd_ferr_a),
        .empty(empty_a), .full(full_a), .count(count_a), .overrun(overrun_a),
        .clr_overrun(clr_a), .busy(busy_a)
    );

    uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_b (
        .clk16(clk16), .reset(reset), .rx(rx_b), .rd_en(rd_en_b),
        .rd_data(rd_data_b), .rd_perr(rd_perr_b), .rd_ferr(rd_ferr_b),
        .empty(empty_b), .full(full_b), .count(count_b), .overrun(overrun_b),
        .clr_overrun(clr_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever the FIFO presents a word
    always @(negedge clk16) begin
        rd_en_a = 1'b0;
        if (mon_a && reset && !empty_a) begin
            if (exp_a.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_word_a: got %0h, expected none",
                         {rd_data_a, rd_perr_a, rd_ferr_a});
            end else begin
                check("word_a", {22'd0, rd_data_a, rd_perr_a, rd_ferr_a}, {22'd0, exp_a.pop_front()});
            end
            rd_en_a = 1'b1;
        end
    end

    always @(negedge clk16) begin
        rd_en_b = 1'b0;
        if (mon_b && reset && !empty_b) begin
            if (exp_b.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_word_b: got %0h, expected none",
                         {rd_data_b, rd_perr_b, rd_ferr_b});
            end else begin
                check("word_b", {22'd0, rd_data_b, rd_perr_b, rd_ferr_b}, {22'd0, exp_b.pop_front()});
            end
            rd_en_b = 1'b1;
        end
    end

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
        repeat (16) @(negedge clk16);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                              input logic par, input logic stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (par_en) drive_bit(sel, par);
        drive_bit(sel, stop);
    endtask

    task automatic drain(input bit sel);
        int n = 0;
        while (((sel ? exp_b.size() : exp_a.size()) != 0) && n < 3000) begin
            @(negedge clk16);
            n++;
        end
        repeat (40) @(negedge clk16);
        check(sel ? "drain_b" : "drain_a", sel ? exp_b.size() : exp_a.size(), 0);
        check(sel ? "empty_b" : "empty_a", sel ? empty_b : empty_a, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] pd;
        repeat (3) @(negedge clk16);
        check("rst_empty", empty_a, 1);
        check("rst_full", full_a, 0);
        check("rst_count", count_a, 0);
        check("rst_overrun", overrun_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_head", {rd_data_a, rd_perr_a, rd_ferr_a}, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk16);

        // Clean 8N1 frame
        exp_a.push_back({8'h55, 2'b00});
        send_frame(0, 8'h55, 0, 1'b0, 1'b1);
        drive_bit(0, 1'b1);
        check("t1_count", count_a, 1);
        check("t1_data", rd_data_a, 8'h55);
        check("t1_flags", {rd_perr_a, rd_ferr_a}, 0);
        mon_a = 1'b1;
        drain(0);
        check("t1_count0", count_a, 0);

        // False start: glitch shorter than half a bit
        rx_a = 1'b0;
        repeat (4) @(negedge clk16);
        check("t2_busy", busy_a, 1);
        rx_a = 1'b1;
        repeat (20) @(negedge clk16);
        check("t2_idle", busy_a, 0);
        check("t2_count", count_a, 0);

        // Framing error, then a 3-frame break yields exactly one 0x00 word
        exp_a.push_back({8'hA3, 2'b01});
        send_frame(0, 8'hA3, 0, 1'b0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        exp_a.push_back({8'h00, 2'b01});
        rx_a = 1'b0;
        repeat (480) @(negedge clk16);
        rx_a = 1'b1;
        drain(0);
        exp_a.push_back({8'h3C, 2'b00});
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
        drive_bit(0, 1'b1);
        drain(0);

        // Even parity on instance b: wrong then correct parity bit
        mon_b = 1'b1;
        exp_b.push_back({8'h07, 2'b10});
        send_frame(1, 8'h07, 1, 1'b0, 1'b1);
        exp_b.push_back({8'h07, 2'b00});
        send_frame(1, 8'h07, 1, 1'b1, 1'b1);
        drive_bit(1, 1'b1);
        drain(1);

        // Fill past depth with no reads
        mon_a = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            send_frame(0, 8'(i), 0, 1'b0, 1'b1);
            if (i <= 8) exp_a.push_back({8'(i), 2'b00});
            if (i == 8) begin
                check("t5_full8", full_a, 1);
                check("t5_count8", count_a, 8);
                check("t5_ovr8", overrun_a, 0);
            end
        end
        drive_bit(0, 1'b1);
        check("t5_overrun", overrun_a, 1);
        check("t5_count9", count_a, 8);
        check("t5_head", rd_data_a, 8'h01);
        mon_a = 1'b1;
        drain(0);
        check("t5_ovr_sticky", overrun_a, 1);
        clr_a = 1'b1;
        @(negedge clk16);
        clr_a = 1'b0;
        check("t5_ovr_clr", overrun_a, 0);

        // Reset at data bit 4 with two words held
        mon_a = 1'b0;
        send_frame(0, 8'h11, 0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 0, 1'b0, 1'b1);
        drive_bit(0, 1'b1);
        check("t6_count2", count_a, 2);
        pd = 8'h5A;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, pd[i]);
        rx_a = pd[4];
        repeat (8) @(negedge clk16);
        check("t6_busy_mid", busy_a, 1);
        reset = 1'b0;
        rx_a = 1'b1;
        repeat (3) @(negedge clk16);
        check("t6_count", count_a, 0);
        check("t6_empty", empty_a, 1);
        check("t6_busy", busy_a, 0);
        reset = 1'b1;
        repeat (32) @(negedge clk16);
        mon_a = 1'b1;
        exp_a.push_back({8'h5A, 2'b00});
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
        drive_bit(0, 1'b1);
        drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
